// File: rtl/mem_dump_pkg.sv
// Shared types and constants for the memory dump engine.
package mem_dump_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } dump_state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mem_dump_engine_sync_fifo.sv
// Show-ahead synchronous FIFO: pop_data always presents the head entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mem_dump_engine.sv
// Streams a contiguous block of memory words out over valid/ready,
// issuing reads only when the output buffer is guaranteed to have room.
module mem_dump_engine
  import mem_dump_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [31:0]       ex_addr,
  input  logic [DATA_W-1:0] ex_data_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] ADDR_MASK = ~32'(WORD_BYTES - 1);

  dump_state_t      state;
  dump_state_t      state_next;
  logic [CNT_W-1:0] issue_rem;
  logic             inflight;
  logic             inflight_last;
  logic             issue;
  logic             issue_final;
  logic             credit_ok;
  logic             pop;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [DATA_W:0]  head;

  // A pop this cycle is deliberately not counted as credit.
  assign credit_ok   = (fifo_count + CW'(inflight)) < CW'(FIFO_DEPTH);
  assign issue       = (state == READ) && credit_ok && !fifo_full && (issue_rem != '0);
  assign issue_final = issue && (issue_rem == CNT_W'(1));
  assign pop         = m_valid && m_ready;

  assign m_valid = !fifo_empty;
  assign m_data  = m_valid ? head[DATA_W-1:0] : '0;
  assign m_last  = m_valid && head[DATA_W];

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight),
    .push_data ({inflight_last, ex_data_out}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (word_count == '0) ? DONE : READ;
      end
      READ: begin
        busy = 1'b1;
        if (issue_final) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && m_last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ex_addr is the address being presented; it stops advancing on the final
  // read so it keeps showing the last issued address afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_addr       <= '0;
      issue_rem     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue_final;
      if ((state == IDLE) && start && (word_count != '0)) begin
        ex_addr   <= base_addr & ADDR_MASK;
        issue_rem <= word_count;
      end else if (issue) begin
        issue_rem <= issue_rem - CNT_W'(1);
        if (!issue_final) ex_addr <= ex_addr + 32'(WORD_BYTES);
      end
    end
  end

endmodule

// File: tb/tb_mem_dump_engine.sv
// Directed bench for mem_dump_engine with a word-queue scoreboard and
// hand-computed checks of latency, addresses and boundary cases.
module tb_mem_dump_engine;

  localparam int          DATA_W     = 32;
  localparam int          CNT_W      = 16;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] MEM_XOR    = 32'hA5A5_0000;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [31:0]       base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              busy;
  logic              done;
  logic [31:0]       ex_addr;
  logic [DATA_W-1:0] ex_data_out = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  int vectors     = 0;
  int miscompares = 0;
  int beat_cnt    = 0;
  logic [DATA_W:0] exp_q[$];
  logic prev_stall = 1'b0;

  mem_dump_engine #(
    .DATA_W     (DATA_W),
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .busy        (busy),
    .done        (done),
    .ex_addr     (ex_addr),
    .ex_data_out (ex_data_out),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last)
  );

  always #5 clock = ~clock;

  // Memory model: data for an address appears one cycle after it is presented.
  always @(posedge clock) ex_data_out <= ex_addr ^ MEM_XOR;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called at cycle 0; returns at cycle 1. Queues the words the dump must produce.
  task automatic applyStimulus(input logic [31:0] base, input int cnt);
    logic [31:0] a;
    base_addr  = base;
    word_count = CNT_W'(cnt);
    start      = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      a = (base & 32'hFFFF_FFFC) + 32'(4 * i);
      exp_q.push_back({(i == cnt - 1), a ^ MEM_XOR});
    end
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input int from, input int max, output int cyc);
    cyc = from;
    while (!done && cyc < max) begin
      tick();
      cyc++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done_timeout: got done=0 expected done=1 by cycle %0d", max);
    end
  endtask

  // Scoreboard: every valid head must match the next expected word.
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !m_valid) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL valid_dropped: got m_valid=0 expected 1 while stalled");
      end
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_beat: got data 0x%08h expected no beat", m_data);
        end else begin
          checkOutput("beat_data", m_data, exp_q[0][DATA_W-1:0]);
          checkOutput("beat_last", 32'(m_last), 32'(exp_q[0][DATA_W]));
          if (m_ready) void'(exp_q.pop_front());
        end
        if (m_ready) beat_cnt++;
      end
      if (done) begin
        checkOutput("done_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("done_busy", 32'(busy), 32'd0);
      end
      prev_stall = m_valid && !m_ready;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;

    tick();
    tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_ex_addr", ex_addr, 32'h0);
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_m_data", m_data, 32'h0);
    checkOutput("rst_m_last", 32'(m_last), 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] basic dump");
    m_ready  = 1'b1;
    beat_cnt = 0;
    applyStimulus(32'h0000_0100, 4);
    checkOutput("basic_c1_busy", 32'(busy), 32'd1);
    checkOutput("basic_c1_addr", ex_addr, 32'h0000_0100);
    checkOutput("basic_c1_valid", 32'(m_valid), 32'd0);
    tick();
    checkOutput("basic_c2_valid", 32'(m_valid), 32'd0);
    checkOutput("basic_c2_addr", ex_addr, 32'h0000_0104);
    tick();
    checkOutput("basic_c3_valid", 32'(m_valid), 32'd1);
    checkOutput("basic_c3_data", m_data, 32'hA5A5_0100);
    checkOutput("basic_c3_last", 32'(m_last), 32'd0);
    tick();
    tick();
    tick();
    checkOutput("basic_c6_data", m_data, 32'hA5A5_010C);
    checkOutput("basic_c6_last", 32'(m_last), 32'd1);
    tick();
    checkOutput("basic_c7_done", 32'(done), 32'd1);
    checkOutput("basic_c7_busy", 32'(busy), 32'd0);
    checkOutput("basic_c7_valid", 32'(m_valid), 32'd0);
    checkOutput("basic_c7_addr", ex_addr, 32'h0000_010C);
    tick();
    checkOutput("basic_c8_done", 32'(done), 32'd0);
    checkOutput("basic_beats", 32'(beat_cnt), 32'd4);

    $display("[TB] backpressure");
    m_ready  = 1'b0;
    beat_cnt = 0;
    applyStimulus(32'h0000_2000, 10);
    repeat (19) tick();
    // Four reads issued; ex_addr now waits on the fifth address.
    checkOutput("bp_frozen_addr", ex_addr, 32'h0000_2010);
    checkOutput("bp_busy", 32'(busy), 32'd1);
    checkOutput("bp_valid", 32'(m_valid), 32'd1);
    checkOutput("bp_head_data", m_data, 32'hA5A5_2000);
    checkOutput("bp_head_last", 32'(m_last), 32'd0);
    m_ready = 1'b1;
    waitDone(20, 80, cyc);
    checkOutput("bp_beats", 32'(beat_cnt), 32'd10);
    checkOutput("bp_final_addr", ex_addr, 32'h0000_2024);
    tick();

    $display("[TB] zero count");
    applyStimulus(32'h0000_5000, 0);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    checkOutput("zero_valid", 32'(m_valid), 32'd0);
    checkOutput("zero_addr", ex_addr, 32'h0000_2024);
    tick();
    checkOutput("zero_done_after", 32'(done), 32'd0);
    checkOutput("zero_valid_after", 32'(m_valid), 32'd0);
    tick();

    $display("[TB] unaligned base and wrap");
    beat_cnt = 0;
    applyStimulus(32'hFFFF_FFFB, 3);
    checkOutput("wrap_addr0", ex_addr, 32'hFFFF_FFF8);
    tick();
    checkOutput("wrap_addr1", ex_addr, 32'hFFFF_FFFC);
    tick();
    checkOutput("wrap_addr2", ex_addr, 32'h0000_0000);
    tick();
    checkOutput("wrap_c4_data", m_data, 32'h5A5A_FFFC);
    waitDone(4, 40, cyc);
    checkOutput("wrap_done_cycle", 32'(cyc), 32'd6);
    checkOutput("wrap_beats", 32'(beat_cnt), 32'd3);
    tick();

    $display("[TB] ignored start with random stall");
    beat_cnt = 0;
    applyStimulus(32'h0000_0400, 12);
    cyc = 1;
    while (!done && cyc < 400) begin
      m_ready = 1'($urandom_range(0, 1));
      if (cyc == 5) begin
        base_addr  = 32'h0000_0800;
        word_count = CNT_W'(3);
        start      = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    checkOutput("rand_done_seen", 32'(done), 32'd1);
    checkOutput("rand_beats", 32'(beat_cnt), 32'd12);
    checkOutput("rand_final_addr", ex_addr, 32'h0000_042C);
    m_ready = 1'b1;
    tick();

    $display("[TB] reset mid-dump");
    beat_cnt = 0;
    applyStimulus(32'h0000_3000, 8);
    tick();
    tick();
    tick();
    checkOutput("rstmid_beat2_valid", 32'(m_valid), 32'd1);
    checkOutput("rstmid_beat2_data", m_data, 32'hA5A5_3004);
    reset = 1'b1;
    tick();
    exp_q.delete();
    checkOutput("rstmid_valid", 32'(m_valid), 32'd0);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    checkOutput("rstmid_addr", ex_addr, 32'h0);
    checkOutput("rstmid_done", 32'(done), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rstmid_no_done", 32'(done), 32'd0);
      checkOutput("rstmid_no_valid", 32'(m_valid), 32'd0);
    end
    beat_cnt = 0;
    applyStimulus(32'h0000_3000, 8);
    waitDone(1, 60, cyc);
    checkOutput("redump_done_cycle", 32'(cyc), 32'd11);
    checkOutput("redump_beats", 32'(beat_cnt), 32'd8);
    checkOutput("redump_addr", ex_addr, 32'h0000_301C);
    tick();

    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_dump_engine.md
# mem_dump_engine

Debug read-out engine sitting directly upstream of the MIPS single-cycle top's external memory port: it drives `ex_addr`, samples `ex_data_out`, and streams a contiguous block of data-memory words out on a valid/ready interface. Used by benches and the board debug path to dump memory after a program run without touching the core. Reads are credit-limited so the output buffer never overflows under any amount of downstream backpressure.

## Interface
- `DATA_W`, 32: word width of `ex_data_out` and `m_data`.
- `CNT_W`, 16: width of `word_count`.
- `FIFO_DEPTH`, 4: output buffer entries; power of two, ≥2.
- `clock`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request a dump; sampled only in IDLE.
- `base_addr`  in  32: byte address of the first word; bits [1:0] ignored (forced 0).
- `word_count`  in  CNT_W: number of words to dump; sampled with `start`.
- `busy`  out  1: high in READ and DRAIN.
- `done`  out  1: one-cycle pulse when the dump completes.
- `ex_addr`  out  32: registered read address to the core's external port.
- `ex_data_out`  in  DATA_W: read data; valid exactly one cycle after `ex_addr` is presented.
- `m_valid`  out  1: output word valid.
- `m_ready`  in  1: consumer accepts the word when `m_valid & m_ready`.
- `m_data`  out  DATA_W: output word.
- `m_last`  out  1: high with the final word of the dump.

## Operation
- FSM: IDLE → READ on `start`. READ → DRAIN when all reads are issued. DRAIN → DONE on handshake of the `m_last` beat. DONE → IDLE unconditionally.
- `start` outside IDLE is ignored.
- `word_count == 0`: IDLE → DONE directly. No reads, no beats, `done` the cycle after `start`.
- Issue rule: in READ, one read per cycle while `fifo_count + inflight < FIFO_DEPTH`. `inflight` is 0 or 1. A pop in the same cycle gives no credit.
- Address: first read at `{base_addr[31:2],2'b00}`, then +4 per issued read. 32-bit wrap 0xFFFF_FFFC → 0x0000_0000 is legal and silent.
- Capture: the cycle after an issue, `ex_data_out` is pushed into the FIFO with a last flag when it is the `word_count`-th read.
- FIFO is show-ahead: `m_data` and `m_last` are the head entry. `m_valid = !empty`.
- `m_data` is held stable while `m_valid & !m_ready`.
- Remaining-count arithmetic is CNT_W bits and unsigned. The issue counter decrements to 0; there is no underflow path.
- Reset mid-dump: FSM to IDLE, FIFO emptied, in-flight read discarded, counters cleared, no `done`.
- Reset values: `busy` 0, `done` 0, `ex_addr` 0x0, `m_valid` 0, `m_data` 0, `m_last` 0.
- `ex_addr` holds the last issued address after completion.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycle 1: READ state, `busy`=1, `ex_addr`=base.
- Cycle 2: first word captured into the FIFO.
- Cycle 3: `m_valid`=1.
- Latency from `start` to the first `m_valid` is 3 cycles.
- With `m_ready` held high: sustained 1 word/cycle. N words take beats in cycles 3..N+2. `done` pulses in cycle N+3, and `busy` is 0 in that cycle.
- With `m_ready` held low: at most FIFO_DEPTH reads are issued, after which `ex_addr` is frozen.

## Structure
- Package `mem_dump_pkg`: state enum `dump_state_t` {IDLE, READ, DRAIN, DONE}, constant `WORD_BYTES = 4`.
- Sub-module `sync_fifo`: show-ahead FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/count, synchronous active-high reset. Instantiated with WIDTH = DATA_W+1 (data plus last flag).
- Top level holds the FSM, the address and remaining counters, the in-flight flag and the credit check.

## Test plan
- Basic dump: base 0x100, count 4, `m_ready`=1, memory model returns addr^0xA5A5_0000 → beats 0xA5A5_0100, _0104, _0108, _010C in cycles 3–6. `m_last` on the 4th beat. `done` in cycle 7.
- Backpressure: count 10, `m_ready`=0 for 20 cycles, then 1 → exactly 4 addresses issued before the stall. All 10 words arrive in order with no loss or duplicate. `m_data` is stable while stalled.
- Zero count: `start` with count 0 → `done` the next cycle. `m_valid` never asserts and `ex_addr` is unchanged.
- Unaligned base and wrap: base 0xFFFF_FFFB, count 3 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Ignored start plus random stall: a second `start` mid-dump has no effect. A random `m_ready` pattern still yields exactly `word_count` beats.
- Reset mid-dump: `reset` for 1 cycle during beat 2 of 8 → next cycle `m_valid`=0, `busy`=0, `ex_addr`=0, no `done`. A new `start` then performs a clean full dump.
